// File: rtl/hilo_div_ctrl_pkg.sv
// Shared pipeline constants: R-type funct codes and HI/LO divider FSM states.
// HILO_MOVE_EN adds MTHI/MTLO to the set of codes that must wait for the divider.
package hilo_div_ctrl_pkg;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMthi = 6'b010001;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [5:0] FnMtlo = 6'b010011;
  localparam logic [5:0] FnDivu = 6'b011011;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam int unsigned DivSteps = 32;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StDiv  = 1'b1
  } div_state_e;

  // Codes that touch HI/LO and so must hold while a divide is in flight.
  function automatic logic hilo_hazard(input logic [5:0] fn);
    logic hz;
    hz = (fn == FnMfhi) || (fn == FnMflo) || (fn == FnDivu);
`ifdef HILO_MOVE_EN
    hz = hz || (fn == FnMthi) || (fn == FnMtlo);
`endif
    return hz;
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// EX-stage <-> HI/LO divider bus: operands and funct in, HI/LO and hazard status out.
interface hilo_div_ctrl_if;
  logic        Valid;
  logic [5:0]  Signal;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        Busy;
  logic        Stall;
  logic        DivDone;

  modport master (
    output Valid, Signal, SrcA, SrcB,
    input  HiOut, LoOut, Busy, Stall, DivDone
  );

  modport slave (
    input  Valid, Signal, SrcA, SrcB,
    output HiOut, LoOut, Busy, Stall, DivDone
  );
endinterface

// File: rtl/divu_step.sv
// One unsigned restoring-division step: shift {rem, quo} left, try-subtract divisor.
module divu_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] partial;
  logic [32:0] diff;

  always_comb begin
    partial = {rem_i, quo_i[31]};
    diff    = partial - {1'b0, divisor_i};
    // No borrow means the divisor fits: keep the difference and shift in a 1.
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = partial[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file with a 32-cycle unsigned divider and pipeline stall generation.
// Define HILO_MOVE_EN to enable MTHI/MTLO writes; otherwise those codes are ignored.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  hilo_div_ctrl_if.slave bus
);

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic        accept_div;

  divu_step u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (rem_nxt),
    .quo_o    (quo_nxt)
  );

  assign accept_div = bus.Valid && (bus.Signal == FnDivu) && (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept_div) begin
            // Quotient register starts as the dividend and is shifted out bit by bit.
            rem_q   <= '0;
            quo_q   <= bus.SrcA;
            dvs_q   <= bus.SrcB;
            cnt_q   <= '0;
            state_q <= StDiv;
          end
`ifdef HILO_MOVE_EN
          else if (bus.Valid && (bus.Signal == FnMthi)) begin
            hi_q <= bus.SrcA;
          end else if (bus.Valid && (bus.Signal == FnMtlo)) begin
            lo_q <= bus.SrcA;
          end
`endif
        end
        StDiv: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DivSteps - 1)) begin
            hi_q    <= rem_nxt;
            lo_q    <= quo_nxt;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.HiOut   = hi_q;
  assign bus.LoOut   = lo_q;
  assign bus.Busy    = (state_q == StDiv);
  assign bus.DivDone = done_q;
  assign bus.Stall   = bus.Valid && (state_q == StDiv) && hilo_hazard(bus.Signal);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: vector table of divides, scoreboard on DivDone,
// and hand sequences for stalls, back-to-back divides, reset abort and MTHI/MTLO.
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_div_ctrl_if bus ();

  hilo_div_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  res_t        sb[$];
  res_t        mon_r;
  vec_t        vecs[8];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Valid  = 1'b0;
    bus.Signal = FnAnd;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
  endtask

  // Present a DIVU for one cycle; returns at the negedge of cycle 1 after the accept edge.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnDivu;
    bus.SrcA   = a;
    bus.SrcB   = b;
    sb.push_back(res_t'{hi, lo});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_busy_drop(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Scoreboard: every DivDone pulse must match the oldest outstanding divide.
  always @(negedge clk) begin
    if (rst_n && bus.DivDone === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_divdone", 32'(bus.DivDone), 32'd0);
      end else begin
        mon_r = sb.pop_front();
        chk("div_hi", bus.HiOut, mon_r.hi);
        chk("div_lo", bus.LoOut, mon_r.lo);
        model_hi = mon_r.hi;
        model_lo = mon_r.lo;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int sc;
    int seen;

    vecs[0] = '{32'd100,        32'd7,          32'd2,        32'd14};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'd0,        32'hFFFF_FFFF};
    vecs[2] = '{32'd55,         32'd0,          32'd55,       32'hFFFF_FFFF};
    vecs[3] = '{32'd0,          32'd5,          32'd0,        32'd0};
    vecs[4] = '{32'd1000,       32'd1000,       32'd0,        32'd1};
    vecs[5] = '{32'd7,          32'd100,        32'd7,        32'd0};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,        32'd1};
    vecs[7] = '{32'h8000_0000,  32'd3,          32'd2,        32'h2AAA_AAAA};

    idle_inputs();
    #3;
    chk("rst_hi", bus.HiOut, 32'd0);
    chk("rst_lo", bus.LoOut, 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.DivDone), 32'd0);
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_div(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      wait_busy_drop(n);
      chk("latency", 32'(n), 32'd32);
      chk("done_pulse", 32'(bus.DivDone), 32'd1);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.DivDone), 32'd0);

    // Back-to-back: a stalled DIVU is taken on the DivDone cycle.
    start_div(32'd12, 32'd5, 32'd2, 32'd2);
    bus.Valid  = 1'b1;
    bus.Signal = FnDivu;
    bus.SrcA   = 32'd50;
    bus.SrcB   = 32'd6;
    #1;
    chk("divu_stall", 32'(bus.Stall), 32'd1);
    wait_busy_drop(n);
    chk("b2b_latency1", 32'(n), 32'd32);
    chk("b2b_stall_release", 32'(bus.Stall), 32'd0);
    chk("b2b_done", 32'(bus.DivDone), 32'd1);
    sb.push_back(res_t'{32'd2, 32'd8});
    @(negedge clk);
    idle_inputs();
    chk("b2b_accept", 32'(bus.Busy), 32'd1);
    wait_busy_drop(n);
    chk("b2b_latency2", 32'(n), 32'd32);

    // MFLO from cycle 5 stalls through cycle 32.
    start_div(32'd100, 32'd7, 32'd2, 32'd14);
    repeat (4) @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnMflo;
    #1;
    chk("lo_hold_during_div", bus.LoOut, model_lo);
    chk("hi_hold_during_div", bus.HiOut, model_hi);
    sc = 0;
    n  = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      if (bus.Stall === 1'b1) sc++;
      @(negedge clk);
      n++;
    end
    chk("mflo_stall_cycles", 32'(sc), 32'd28);
    chk("mflo_stall_drop", 32'(bus.Stall), 32'd0);
    chk("mflo_lo_valid", bus.LoOut, 32'd14);
    idle_inputs();

    // Reset at cycle 10 of 9/3 with HI/LO preloaded.
    start_div(32'd9, 32'd3, 32'd0, 32'd3);
    @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnAdd;
    #1;
    chk("ignored_no_stall", 32'(bus.Stall), 32'd0);
    idle_inputs();
    repeat (8) @(negedge clk);
    chk("preload_hi", bus.HiOut, 32'd2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_hi", bus.HiOut, 32'd0);
    chk("abort_lo", bus.LoOut, 32'd0);
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.DivDone), 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0 || bus.DivDone !== 1'b0) seen = 1;
    end
    chk("no_activity_after_abort", 32'(seen), 32'd0);
    start_div(32'd9, 32'd3, 32'd0, 32'd3);
    wait_busy_drop(n);
    chk("post_reset_latency", 32'(n), 32'd32);

`ifdef HILO_MOVE_EN
    @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnMthi;
    bus.SrcA   = 32'h1234;
    @(negedge clk);
    idle_inputs();
    chk("mthi_write", bus.HiOut, 32'h1234);
    chk("mthi_lo_kept", bus.LoOut, 32'd3);
    start_div(32'd100, 32'd7, 32'd2, 32'd14);
    @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnMtlo;
    bus.SrcA   = 32'hDEAD;
    #1;
    chk("mtlo_stall", 32'(bus.Stall), 32'd1);
    chk("mtlo_lo_unchanged", bus.LoOut, 32'd3);
    wait_busy_drop(n);
    chk("mtlo_div_result", bus.LoOut, 32'd14);
    @(negedge clk);
    idle_inputs();
    chk("mtlo_after_div", bus.LoOut, 32'hDEAD);
`else
    @(negedge clk);
    bus.Valid  = 1'b1;
    bus.Signal = FnMthi;
    bus.SrcA   = 32'h1234;
    #1;
    chk("mthi_ignored_stall", 32'(bus.Stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    chk("mthi_ignored_hi", bus.HiOut, 32'd0);
    chk("mthi_ignored_busy", 32'(bus.Busy), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
